imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the processor's 512-word instruction memory. It accepts a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words. Each word is written into the instruction RAM at incrementing word addresses starting at 0. The processor is held in reset until the image is loaded and its checksum verifies. The block sits between the host byte link and the write port of the instruction RAM that the processor fetches from.

## Interface
- DEPTH, 512, instruction memory depth in words; address width fixed at 9.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready on a clock edge.
- mem_we  out  1  one-cycle write strobe to the instruction RAM.
- mem_adrs  out  9  RAM word address.
- mem_din  out  32  RAM write data.
- cpu_hold  out  1  processor reset/stall request.
- done  out  1  load completed and checksum matched; level.
- err  out  1  load failed; level.
- words_loaded  out  10  number of mem_we pulses issued in the current load.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 payload bytes: each word most-significant byte first.
  - One CSUM byte: the 8-bit modulo-256 sum of all payload bytes. Length bytes are excluded.
- States and transitions:
  - IDLE: start → S_LENH.
  - S_LENH: accept a byte → S_LENL.
  - S_LENL: accept a byte → S_DATA if 1 ≤ N ≤ DEPTH, else ERR.
  - S_DATA: stays until the 4N-th byte is accepted → S_CSUM.
  - S_CSUM: accept a byte → DONE if it equals the running sum, else ERR.
  - DONE and ERR: start → S_LENH.
- in_ready is 1 in S_LENH, S_LENL, S_DATA and S_CSUM, and 0 otherwise. The loader never stalls mid-frame.
- Word assembly:
  - A 2-bit byte counter shifts each byte into a 32-bit shift register.
  - On acceptance of byte index 3 of a word, the next edge registers mem_din = assembled word and mem_adrs = word index, and asserts mem_we for exactly one cycle.
  - words_loaded increments with each mem_we.
- Word index starts at 0 on each start and increments after each write. It cannot exceed DEPTH-1 because N is validated.
- On start, the following are cleared: word index, words_loaded, byte counter, running sum, done, err.
- cpu_hold:
  - 1 out of reset and in every state except DONE.
  - Falls to 0 on entry to DONE.
  - Rises again on start.
- ERR is sticky until start or rst. Words already written are not rolled back.
- start is ignored while in S_LENH, S_LENL, S_DATA or S_CSUM.
- in_valid while in_ready = 0 is ignored. No byte is consumed.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_adrs 0, mem_din 0, cpu_hold 1, done 0, err 0, words_loaded 0.
- start at edge k: in_ready = 1 from cycle k+1.
- Write latency: the 4th byte of a word accepted at edge t gives mem_we = 1 during cycle t+1, with mem_adrs and mem_din stable in that cycle.
- Back-to-back bytes at full rate, one per cycle, are sustained. One write is issued every 4 cycles.
- Last payload byte and CSUM byte on consecutive cycles: the final mem_we overlaps the cycle in which CSUM is accepted. The final write still completes.
- CSUM accepted at edge c:
  - State DONE or ERR is visible from cycle c+1.
  - done or err = 1 from cycle c+1.
  - cpu_hold = 0 from cycle c+1 on a match.
- Bad length accepted at edge l: err = 1 and in_ready = 0 from cycle l+1. No mem_we is issued.
- Reset asserted mid-frame: every output returns to its reset value immediately (asynchronous). A partial word is never written.

## Test plan
- Nominal load:
  - Stimulus: start, then 00 03 3C 01 10 01 34 30 00 00 24 04 00 3F 19 at full rate.
  - Required: writes (0, 0x3C011001), (1, 0x34300000), (2, 0x2404003F), each mem_we one cycle.
  - Then done = 1, err = 0, cpu_hold = 0, words_loaded = 3.
- Bad checksum: same frame with CSUM = 0x18 → all 3 writes occur, then err = 1, done = 0, cpu_hold stays 1.
- Length bounds:
  - N = 0x0000 → err the cycle after LEN_LO, zero writes.
  - N = 0x0201 → err.
  - N = 0x0200 with a full 2048-byte payload → last write at address 511, words_loaded = 512.
- Throttled input: random in_valid gaps, including gaps inside a word → identical writes and result to the nominal load. No byte is lost or duplicated.
- Restart behaviour:
  - start pulsed mid-payload → ignored, load completes normally.
  - start from ERR → counters cleared and a new frame loads at address 0.
- Reset mid-word: assert rst after 2 bytes of word 1 → all outputs at reset values, no write to address 1. A following full load succeeds.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the processor instruction RAM. It receives a framed byte
// stream and assembles big-endian 32-bit words. The words are written to the
// RAM at word addresses 0, 1, 2, ... The processor is held in reset until the
// whole image has arrived and its checksum matches.
//
// Frame: LEN_HI, LEN_LO (word count N, 1..DEPTH), then N*4 payload bytes with
// the MSB of each word first, then one CSUM byte. CSUM is the modulo-256 sum
// of the payload bytes only.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         one-cycle pulse, honoured in IDLE / DONE / ERR only
//   in_valid      a byte is present on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   mem_we        one-cycle RAM write strobe
//   mem_adrs      RAM word address
//   mem_din       RAM write data
//   cpu_hold      processor reset/stall request, low only in DONE
//   done          image loaded and checksum matched (level)
//   err           bad length or bad checksum (level, sticky until start/rst)
//   words_loaded  number of writes issued in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [8:0]  mem_adrs,
    output logic [31:0] mem_din,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [9:0]  words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_LENH = 3'd1,
        S_LENL = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t      state_reg, state_next;

    logic [7:0]  len_hi_reg;
    logic [9:0]  n_reg;          // validated word count; fits in 10 bits
    logic [1:0]  byte_cnt_reg;
    logic [23:0] shift_reg;      // first three bytes of the word in progress
    logic [7:0]  sum_reg;
    logic [9:0]  word_cnt_reg;   // completed words in this frame

    logic        accept;
    logic        start_ok;
    logic [15:0] len_n;
    logic        len_ok;
    logic        last_byte;
    logic        last_word;
    logic        csum_ok;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE) ||
                                 (state_reg == ERR));
    assign len_n     = {len_hi_reg, in_data};
    assign len_ok    = (len_n != 16'd0) && (len_n <= 16'(DEPTH));
    assign last_byte = (byte_cnt_reg == 2'd3);
    assign last_word = ((word_cnt_reg + 10'd1) == n_reg);
    // The last payload byte is added to sum_reg at its own acceptance edge,
    // so sum_reg is complete by the time CSUM can arrive.
    assign csum_ok   = (in_data == sum_reg);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = S_LENH;
            end
            S_LENH: begin
                in_ready = 1'b1;
                if (accept) state_next = S_LENL;
            end
            S_LENL: begin
                in_ready = 1'b1;
                if (accept) state_next = len_ok ? S_DATA : ERR;
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (accept && last_byte && last_word) state_next = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (accept) state_next = csum_ok ? DONE : ERR;
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) state_next = S_LENH;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = S_LENH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, checksum and RAM write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi_reg   <= 8'd0;
            n_reg        <= 10'd0;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 24'd0;
            sum_reg      <= 8'd0;
            word_cnt_reg <= 10'd0;
            mem_we       <= 1'b0;
            mem_adrs     <= 9'd0;
            mem_din      <= 32'd0;
            words_loaded <= 10'd0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                byte_cnt_reg <= 2'd0;
                sum_reg      <= 8'd0;
                word_cnt_reg <= 10'd0;
                words_loaded <= 10'd0;
            end
            if (accept) begin
                case (state_reg)
                    S_LENH: len_hi_reg <= in_data;
                    S_LENL: n_reg      <= len_n[9:0];
                    S_DATA: begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        sum_reg      <= sum_reg + in_data;
                        shift_reg    <= {shift_reg[15:0], in_data};
                        if (last_byte) begin
                            mem_we       <= 1'b1;
                            mem_adrs     <= word_cnt_reg[8:0];
                            mem_din      <= {shift_reg, in_data};
                            word_cnt_reg <= word_cnt_reg + 10'd1;
                            words_loaded <= word_cnt_reg + 10'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Scoreboard bench for imem_loader. Stimulus tasks push every expected RAM
// write (address, data) into exp_q as frames are built. An independent monitor
// pops and compares on every mem_we. Status outputs are compared directly at
// known cycles.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [8:0]  mem_adrs;
    logic [31:0] mem_din;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [9:0]  words_loaded;

    int          pass_cnt  = 0;
    int          total_cnt = 0;

    logic [40:0] exp_q[$];     // {adrs, data}
    logic [7:0]  frame_q[$];
    logic [8:0]  last_adrs = 9'd0;
    logic        prev_we   = 1'b0;

    imem_loader #(.DEPTH(512)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_adrs     (mem_adrs),
        .mem_din      (mem_din),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
            $display("check %s: 0x%0h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        logic [40:0] e;
        if (mem_we) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got adrs=%0d din=0x%08h, required no write",
                         mem_adrs, mem_din);
            end else begin
                e = exp_q.pop_front();
                if ({mem_adrs, mem_din} === e && !prev_we) begin
                    pass_cnt++;
                    $display("write adrs=%0d din=0x%08h ok", mem_adrs, mem_din);
                end else begin
                    $display("FAIL write: got adrs=%0d din=0x%08h prev_we=%0b, required adrs=%0d din=0x%08h prev_we=0",
                             mem_adrs, mem_din, prev_we, e[40:32], e[31:0]);
                end
            end
            last_adrs = mem_adrs;
        end
        prev_we = mem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("in_ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic push_word(input logic [8:0] adrs, input logic [31:0] w);
        exp_q.push_back({adrs, w});
    endtask

    task automatic add_word(input logic [31:0] w);
        frame_q.push_back(w[31:24]);
        frame_q.push_back(w[23:16]);
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[7:0]);
    endtask

    // Nominal frame; expected writes are hand-written constants.
    task automatic build_nominal(input logic [7:0] csum);
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h03);
        add_word(32'h3C011001);
        add_word(32'h34300000);
        add_word(32'h2404003F);
        frame_q.push_back(csum);
        push_word(9'd0, 32'h3C011001);
        push_word(9'd1, 32'h34300000);
        push_word(9'd2, 32'h2404003F);
    endtask

    // Send frame_q. max_gap > 0 inserts random idle cycles before each byte.
    // start_at >= 0 pulses start together with that byte.
    task automatic send_frame(input int max_gap, input int start_at);
        int gap;
        for (int i = 0; i < frame_q.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) tick();
            in_valid = 1'b1;
            in_data  = frame_q[i];
            start    = (i == start_at);
            tick();
            start    = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},     32'(in_ready),     32'd0);
        check({tag, "_mem_we"},       32'(mem_we),       32'd0);
        check({tag, "_mem_adrs"},     32'(mem_adrs),     32'd0);
        check({tag, "_mem_din"},      mem_din,           32'd0);
        check({tag, "_cpu_hold"},     32'(cpu_hold),     32'd1);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_err"},          32'(err),          32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic check_done(input string tag, input logic [9:0] nwords);
        check({tag, "_done"},         32'(done),         32'd1);
        check({tag, "_err"},          32'(err),          32'd0);
        check({tag, "_cpu_hold"},     32'(cpu_hold),     32'd0);
        check({tag, "_in_ready"},     32'(in_ready),     32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(nwords));
    endtask

    task automatic check_drained(input string tag);
        tick();
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  s;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check_reset_values("reset");
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Nominal load at full rate
        build_nominal(8'h19);
        do_start();
        send_frame(0, -1);
        check_done("nominal", 10'd3);
        check_drained("nominal");

        // Bad checksum: all writes happen, then ERR
        build_nominal(8'h18);
        do_start();
        send_frame(0, -1);
        check("badcsum_err",      32'(err),          32'd1);
        check("badcsum_done",     32'(done),         32'd0);
        check("badcsum_cpu_hold", 32'(cpu_hold),     32'd1);
        check("badcsum_words",    32'(words_loaded), 32'd3);
        check_drained("badcsum");

        // Restart from ERR clears counters and reloads from address 0
        build_nominal(8'h19);
        do_start();
        check("restart_err_clr",   32'(err),          32'd0);
        check("restart_words_clr", 32'(words_loaded), 32'd0);
        send_frame(0, -1);
        check_done("restart", 10'd3);
        check_drained("restart");

        // Length N = 0
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h00);
        do_start();
        send_frame(0, -1);
        check("len0_err",      32'(err),          32'd1);
        check("len0_in_ready", 32'(in_ready),     32'd0);
        check("len0_words",    32'(words_loaded), 32'd0);
        repeat (3) tick();

        // Length N = 0x0201
        frame_q.delete();
        frame_q.push_back(8'h02);
        frame_q.push_back(8'h01);
        do_start();
        send_frame(0, -1);
        check("len513_err",      32'(err),      32'd1);
        check("len513_in_ready", 32'(in_ready), 32'd0);
        check("len513_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (3) tick();

        // Throttled input with gaps inside words
        build_nominal(8'h19);
        do_start();
        send_frame(3, -1);
        check_done("throttled", 10'd3);
        check_drained("throttled");

        // start pulsed mid-payload is ignored
        build_nominal(8'h19);
        do_start();
        send_frame(0, 6);
        check_done("midstart", 10'd3);
        check_drained("midstart");

        // Reset after two bytes of word 1: only word 0 is written
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h02);
        add_word(32'h11223344);
        frame_q.push_back(8'h55);
        frame_q.push_back(8'h66);
        push_word(9'd0, 32'h11223344);
        do_start();
        send_frame(0, -1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        check("midreset_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        build_nominal(8'h19);
        do_start();
        send_frame(0, -1);
        check_done("after_reset", 10'd3);
        check_drained("after_reset");

        // Full-depth load, N = 512
        frame_q.delete();
        frame_q.push_back(8'h02);
        frame_q.push_back(8'h00);
        s = 8'h00;
        for (int i = 0; i < 512; i++) begin
            w = {8'(i), 8'(i >> 8), 8'hA5, ~8'(i)};
            add_word(w);
            push_word(9'(i), w);
            s = s + w[31:24] + w[23:16] + w[15:8] + w[7:0];
        end
        frame_q.push_back(s);
        do_start();
        send_frame(0, -1);
        check_done("full", 10'd512);
        check("full_last_adrs", 32'(last_adrs), 32'd511);
        check_drained("full");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
